// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator (default 1280x720@60 from a 74.25 MHz pixel clock).
// Requests pixel coordinates one cycle ahead of the active region so that the
// registered pixel_data from the display source lines up with video_de.
// Optional build macro: VTG_SYNC_NEG_EN makes video_hs/video_vs active-low (idle 1).
module video_timing_gen #(
  parameter logic [10:0] H_SYNC  = 11'd40,
  parameter logic [10:0] H_BACK  = 11'd220,
  parameter logic [10:0] H_DISP  = 11'd1280,
  parameter logic [10:0] H_FRONT = 11'd110,
  parameter logic [10:0] V_SYNC  = 11'd5,
  parameter logic [10:0] V_BACK  = 11'd20,
  parameter logic [10:0] V_DISP  = 11'd720,
  parameter logic [10:0] V_FRONT = 11'd5
) (
  input  logic        pixel_clk,
  input  logic        sys_rst,
  input  logic [23:0] pixel_data,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic        data_req,
  output logic        video_hs,
  output logic        video_vs,
  output logic        video_de,
  output logic [23:0] video_rgb,
  output logic        frame_start
);

  localparam logic [10:0] H_TOTAL     = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam logic [10:0] V_TOTAL     = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam logic [10:0] HA          = H_SYNC + H_BACK;
  localparam logic [10:0] VA          = V_SYNC + V_BACK;
  // Request window opens one pixel early to cover the source's register stage.
  localparam logic [10:0] H_REQ_START = HA - 11'd1;
  localparam logic [10:0] H_REQ_END   = HA + H_DISP - 11'd1;
  localparam logic [10:0] V_REQ_END   = VA + V_DISP;

`ifdef VTG_SYNC_NEG_EN
  localparam logic SYNC_IDLE = 1'b1;
`else
  localparam logic SYNC_IDLE = 1'b0;
`endif

  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic        h_last;
  logic        v_last;
  logic        h_in_req;
  logic        v_in_req;

  assign h_last = (h_cnt == H_TOTAL - 11'd1);
  assign v_last = (v_cnt == V_TOTAL - 11'd1);

  // Horizontal pixel counter, wraps at end of line.
  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      h_cnt <= 11'd0;
    end else if (h_last) begin
      h_cnt <= 11'd0;
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  // Vertical line counter, advances on the last pixel of each line; wraps with h_cnt.
  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      v_cnt <= 11'd0;
    end else if (h_last) begin
      if (v_last) begin
        v_cnt <= 11'd0;
      end else begin
        v_cnt <= v_cnt + 11'd1;
      end
    end
  end

  assign h_in_req = (h_cnt >= H_REQ_START) && (h_cnt < H_REQ_END);
  assign v_in_req = (v_cnt >= VA) && (v_cnt < V_REQ_END);
  assign data_req = h_in_req && v_in_req;

  // Coordinates are forced to zero outside the request window.
  assign pixel_xpos = data_req ? (h_cnt - H_REQ_START) : 11'd0;
  assign pixel_ypos = data_req ? (v_cnt - VA) : 11'd0;

  // Sync, enable and frame marker, all one cycle behind the counters.
  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      video_de    <= 1'b0;
      video_hs    <= SYNC_IDLE;
      video_vs    <= SYNC_IDLE;
      frame_start <= 1'b0;
    end else begin
      video_de    <= data_req;
      video_hs    <= (h_cnt < H_SYNC) ? ~SYNC_IDLE : SYNC_IDLE;
      video_vs    <= (v_cnt < V_SYNC) ? ~SYNC_IDLE : SYNC_IDLE;
      frame_start <= data_req && (pixel_xpos == 11'd0) && (pixel_ypos == 11'd0);
    end
  end

  assign video_rgb = video_de ? pixel_data : 24'h0;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: randomized self-checking bench for video_timing_gen.
// A small-geometry instance is checked every cycle against an arithmetic raster
// model; a default-geometry instance checks the 720p first-request position.
`timescale 1ns/1ps
module tb_video_timing_gen;

  localparam int HS = 4, HB = 6, HD = 16, HF = 5;
  localparam int VS = 2, VB = 3, VD = 8,  VF = 2;
  localparam int HT = HS + HB + HD + HF;
  localparam int VT = VS + VB + VD + VF;
  localparam int FT = HT * VT;
  localparam int HA = HS + HB;
  localparam int VA = VS + VB;
  localparam int FIRST_REQ     = VA * HT + HA - 1;
  localparam int BIG_FIRST_REQ = 25 * 1650 + 259;

`ifdef VTG_SYNC_NEG_EN
  localparam logic POL = 1'b1;
`else
  localparam logic POL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        big_rst = 1'b1;
  logic [23:0] pixel_data = 24'h0;
  logic [1:0]  hi_reg = 2'b0;
  logic [10:0] pixel_xpos, pixel_ypos;
  logic        data_req, video_hs, video_vs, video_de, frame_start;
  logic [23:0] video_rgb;

  logic [23:0] big_pixel_data = 24'h0;
  logic [10:0] big_xpos, big_ypos;
  logic        big_req, big_hs, big_vs, big_de, big_fs;
  logic [23:0] big_rgb;

  int checks = 0;
  int errors = 0;
  int tick = 0;
  int big_tick = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_SYNC(11'(HS)), .H_BACK(11'(HB)), .H_DISP(11'(HD)), .H_FRONT(11'(HF)),
    .V_SYNC(11'(VS)), .V_BACK(11'(VB)), .V_DISP(11'(VD)), .V_FRONT(11'(VF))
  ) dut (
    .pixel_clk(clk), .sys_rst(sys_rst), .pixel_data(pixel_data),
    .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos), .data_req(data_req),
    .video_hs(video_hs), .video_vs(video_vs), .video_de(video_de),
    .video_rgb(video_rgb), .frame_start(frame_start)
  );

  video_timing_gen dut_big (
    .pixel_clk(clk), .sys_rst(big_rst), .pixel_data(big_pixel_data),
    .pixel_xpos(big_xpos), .pixel_ypos(big_ypos), .data_req(big_req),
    .video_hs(big_hs), .video_vs(big_vs), .video_de(big_de),
    .video_rgb(big_rgb), .frame_start(big_fs)
  );

  // Clock edges elapsed since reset release (position in the raster stream).
  always @(posedge clk or posedge sys_rst) begin
    if (sys_rst) tick <= 0;
    else         tick <= tick + 1;
  end

  always @(posedge clk or posedge big_rst) begin
    if (big_rst) big_tick <= 0;
    else         big_tick <= big_tick + 1;
  end

  // Display source model: registers the requested coordinate plus random tag bits.
  always @(posedge clk) begin
    logic [1:0] r;
    r = 2'($urandom_range(0, 3));
    pixel_data <= {r, pixel_xpos, pixel_ypos};
    hi_reg     <= r;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Raster model: position p counts pixels from the frame origin.
  function automatic int h_of(int p); return p % HT; endfunction
  function automatic int v_of(int p); return (p / HT) % VT; endfunction
  function automatic bit req_of(int p);
    return (h_of(p) >= HA - 1) && (h_of(p) < HA + HD - 1) &&
           (v_of(p) >= VA) && (v_of(p) < VA + VD);
  endfunction
  function automatic int x_of(int p); return req_of(p) ? h_of(p) - (HA - 1) : 0; endfunction
  function automatic int y_of(int p); return req_of(p) ? v_of(p) - VA : 0; endfunction

  task automatic check_reset_state(input string pfx);
    check({pfx, "_req"},  32'(data_req),    32'd0);
    check({pfx, "_xpos"}, 32'(pixel_xpos),  32'd0);
    check({pfx, "_ypos"}, 32'(pixel_ypos),  32'd0);
    check({pfx, "_de"},   32'(video_de),    32'd0);
    check({pfx, "_hs"},   32'(video_hs),    32'(POL));
    check({pfx, "_vs"},   32'(video_vs),    32'(POL));
    check({pfx, "_fs"},   32'(frame_start), 32'd0);
    check({pfx, "_rgb"},  32'(video_rgb),   32'd0);
  endtask

  task automatic check_cycle();
    int q;
    logic e_de, e_hs, e_vs, e_fs;
    logic [10:0] ex, ey;
    logic [23:0] e_rgb;
    if (sys_rst) begin
      check_reset_state("cyc_rst");
    end else begin
      check("cyc_req",  32'(data_req),   32'(req_of(tick)));
      check("cyc_xpos", 32'(pixel_xpos), 32'(x_of(tick)));
      check("cyc_ypos", 32'(pixel_ypos), 32'(y_of(tick)));
      if (tick == 0) begin
        e_de = 1'b0; e_hs = POL; e_vs = POL; e_fs = 1'b0; e_rgb = 24'h0;
      end else begin
        q     = tick - 1;
        e_de  = req_of(q);
        e_hs  = (h_of(q) < HS) ? ~POL : POL;
        e_vs  = (v_of(q) < VS) ? ~POL : POL;
        e_fs  = (h_of(q) == HA - 1) && (v_of(q) == VA);
        ex    = 11'(x_of(q));
        ey    = 11'(y_of(q));
        e_rgb = e_de ? {hi_reg, ex, ey} : 24'h0;
      end
      check("cyc_de",  32'(video_de),    32'(e_de));
      check("cyc_hs",  32'(video_hs),    32'(e_hs));
      check("cyc_vs",  32'(video_vs),    32'(e_vs));
      check("cyc_fs",  32'(frame_start), 32'(e_fs));
      check("cyc_rgb", 32'(video_rgb),   32'(e_rgb));
    end
  endtask

  always @(negedge clk) if (chk_en) check_cycle();

  initial begin
    int n;
    int de_cnt, vs_cnt, fs_cnt, fs_last, fs_gap, fs_first;
    int hs_last, hs_gap, de_bursts, de_run, x_max, y_max, req_first;
    logic prev_hs, prev_de;

    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    #1 check_reset_state("init");

    @(posedge clk); #1 sys_rst = 1'b0; big_rst = 1'b0;
    $display("release at %0t", $time);

    // Two full frames of aggregate timing.
    de_cnt = 0; vs_cnt = 0; fs_cnt = 0; fs_last = -1; fs_gap = -1; fs_first = -1;
    hs_last = -1; hs_gap = -1; de_bursts = 0; de_run = 0; x_max = 0; y_max = 0;
    req_first = -1; prev_hs = POL; prev_de = 1'b0;
    for (int i = 0; i <= 2 * FT; i++) begin
      @(negedge clk);
      if (video_de) de_cnt++;
      if (video_vs != POL) vs_cnt++;
      if (frame_start) begin
        if (fs_last >= 0) fs_gap = tick - fs_last;
        if (fs_first < 0) fs_first = tick;
        fs_last = tick;
        fs_cnt++;
      end
      if ((video_hs != POL) && (prev_hs == POL)) begin
        if (hs_last >= 0) hs_gap = tick - hs_last;
        hs_last = tick;
      end
      if (video_de) de_run++;
      if (video_de && !prev_de) de_bursts++;
      if (!video_de && prev_de) begin
        check("de_burst_len", 32'(de_run), 32'(HD));
        de_run = 0;
      end
      if (data_req && req_first < 0) req_first = tick;
      if (data_req && int'(pixel_xpos) > x_max) x_max = int'(pixel_xpos);
      if (data_req && int'(pixel_ypos) > y_max) y_max = int'(pixel_ypos);
      prev_hs = video_hs;
      prev_de = video_de;
    end
    check("first_req_tick", 32'(req_first), 32'(FIRST_REQ));
    check("first_fs_tick",  32'(fs_first),  32'(FIRST_REQ + 1));
    check("fs_count",       32'(fs_cnt),    32'd2);
    check("fs_period",      32'(fs_gap),    32'(FT));
    check("de_total",       32'(de_cnt),    32'(2 * HD * VD));
    check("de_bursts",      32'(de_bursts), 32'(2 * VD));
    check("vs_active",      32'(vs_cnt),    32'(2 * VS * HT));
    check("hs_period",      32'(hs_gap),    32'(HT));
    check("x_max",          32'(x_max),     32'(HD - 1));
    check("y_max",          32'(y_max),     32'(VD - 1));
    $display("two frames: de %0d vs %0d fs %0d", de_cnt, vs_cnt, fs_cnt);

    // Reset episodes: first at line 6 pixel 20, the rest at random points.
    for (int e = 0; e < 5; e++) begin
      if (e == 0) begin
        n = 0;
        while ((tick % FT) != 6 * HT + 20 && n < 2 * FT) begin @(negedge clk); n++; end
        check("reset_target_reached", 32'(tick % FT), 32'(6 * HT + 20));
      end else begin
        repeat ($urandom_range(1, 2 * FT)) @(negedge clk);
      end
      #2 sys_rst = 1'b1;
      #1 check_reset_state("midrst");
      repeat (3) @(posedge clk);
      #1 sys_rst = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!data_req && n < FT + 5);
      check("restart_req_tick", 32'(tick), 32'(FIRST_REQ));
      check("restart_req_x",    32'(pixel_xpos), 32'd0);
      check("restart_req_y",    32'(pixel_ypos), 32'd0);
      @(negedge clk);
      check("restart_fs", 32'(frame_start), 32'd1);
      $display("reset episode %0d restart latency %0d", e, tick - 1);
    end

    // Default 720p geometry: first request position.
    n = 0;
    while (!big_req && n < 50000) begin @(negedge clk); n++; end
    check("big_first_req_tick", 32'(big_tick), 32'(BIG_FIRST_REQ));
    check("big_first_req_x",    32'(big_xpos), 32'd0);
    check("big_first_req_y",    32'(big_ypos), 32'd0);
    @(negedge clk);
    check("big_fs", 32'(big_fs), 32'd1);
    check("big_de", 32'(big_de), 32'd1);
    $display("720p first request at tick %0d", big_tick - 1);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Generates 1280x720@60 raster timing from `pixel_clk` (74.25 MHz).
- Drives `pixel_xpos`/`pixel_ypos` to `video_display` one cycle ahead of the active region, to absorb its registered `pixel_data` stage.
- Outputs aligned `video_hs`/`video_vs`/`video_de`/`video_rgb` to the HDMI/RGB encoder downstream.

## Interface
Parameters:
- `H_SYNC`, 11'd40, hsync pulse width (pixels)
- `H_BACK`, 11'd220, horizontal back porch
- `H_DISP`, 11'd1280, active pixels per line
- `H_FRONT`, 11'd110, horizontal front porch
- `V_SYNC`, 11'd5, vsync pulse width (lines)
- `V_BACK`, 11'd20, vertical back porch
- `V_DISP`, 11'd720, active lines
- `V_FRONT`, 11'd5, vertical front porch

Ports:
- `pixel_clk` input 1: pixel clock; one clock domain, all logic on rising edge
- `sys_rst` input 1: reset, asynchronous, active-high
- `pixel_data` input 24: RGB from `video_display`, registered there
- `pixel_xpos` output 11: requested column, 0..H_DISP-1; 0 outside request window
- `pixel_ypos` output 11: requested row, 0..V_DISP-1; 0 outside request window
- `data_req` output 1: xpos/ypos valid this cycle
- `video_hs` output 1: horizontal sync
- `video_vs` output 1: vertical sync
- `video_de` output 1: active video
- `video_rgb` output 24: `pixel_data` when `video_de`, else 24'h0
- `frame_start` output 1: one-cycle pulse on first `data_req` of each frame

## Operation
- Derived totals: `H_TOTAL = H_SYNC+H_BACK+H_DISP+H_FRONT` (1650); `V_TOTAL` (750). All arithmetic is 11-bit unsigned; parameters must keep totals ≤ 2047.
- Line order: sync, back porch, active, front porch. The same order applies vertically.
- `h_cnt` counts 0..H_TOTAL-1 and wraps to 0.
- `v_cnt` increments only in the cycle `h_cnt == H_TOTAL-1`. It wraps to 0 when it is also V_TOTAL-1, giving a simultaneous double wrap.
- Let `HA = H_SYNC+H_BACK` and `VA = V_SYNC+V_BACK`.
- `data_req` (combinational from counters) = `h_cnt` in [HA-1, HA+H_DISP-1) AND `v_cnt` in [VA, VA+V_DISP).
- When `data_req`=1:
  - `pixel_xpos = h_cnt-(HA-1)`
  - `pixel_ypos = v_cnt-VA`
- When `data_req`=0, `pixel_xpos`/`pixel_ypos` = 0.
- Registered from counters, each 1-cycle delayed:
  - `video_de` = registered `data_req`
  - `video_hs` = registered (`h_cnt < H_SYNC`)
  - `video_vs` = registered (`v_cnt < V_SYNC`)
- `video_rgb` = `video_de ? pixel_data : 0`, combinational.
- `frame_start` = registered (`data_req` && `pixel_xpos==0` && `pixel_ypos==0`). It is therefore high in the first `video_de` cycle of the frame.

## Timing
- Reset (`sys_rst`=1, asynchronous assert):
  - `h_cnt`=`v_cnt`=0.
  - `video_hs`/`video_vs`/`video_de`/`frame_start`=0.
  - `pixel_xpos`/`pixel_ypos`/`data_req`=0.
  - `video_rgb`=0.
- Release is sampled on `pixel_clk`; the first rising edge after deassertion begins counting from line 0, pixel 0.
- Reset mid-frame: outputs drop immediately. After release the frame restarts at `h_cnt=v_cnt=0`; no partial line is completed.
- Request-to-pixel latency is exactly 1 cycle. `pixel_data` for coordinate (x,y) requested in cycle N is presented with `video_de`=1 in cycle N+1.
- Per line: `video_hs` high H_SYNC cycles; `video_de` high exactly H_DISP consecutive cycles on active lines and never on blanking lines.
- `video_vs` high V_SYNC×H_TOTAL cycles, with edges coincident with `video_hs` rising.
- Frame period is H_TOTAL×V_TOTAL = 1,237,500 cycles.

## Configuration
- Macro `VTG_SYNC_NEG_EN`.
  - Defined: `video_hs`/`video_vs` are active-low (idle 1). Their reset value is 1.
  - Undefined (default, 720p standard): active-high, reset value 0.
- `video_de`, `data_req` and `frame_start` are unaffected by the macro.

## Test plan
- Release reset with default parameters. Required: first `data_req` in the cycle with `h_cnt=259` on line 25, with `pixel_xpos=0`, `pixel_ypos=0`. `frame_start`=1 and `video_de`=1 in the next cycle.
- Count cycles on an active line. Required: `video_de` high 1280 cycles; `video_hs` rising edges 1650 cycles apart; last `pixel_xpos`=1279; `pixel_xpos`=0 after the window.
- Run 2 full frames. Required: `frame_start` pulses 1,237,500 cycles apart; `video_vs` high 8250 cycles; 720 `video_de` bursts per frame; last `pixel_ypos`=719.
- Model `pixel_data` as {xpos,ypos} registered 1 cycle. Required: `video_rgb` equals {x,y} of the pixel in every `video_de` cycle, and 0 in blanking.
- Assert `sys_rst` at line 400, pixel 900, for 3 cycles. Required: all outputs 0 immediately; next `data_req` exactly 25×1650+259 cycles after release.
- Compile with `VTG_SYNC_NEG_EN` and small parameters (H 2/2/8/2, V 1/1/4/1). Required: `video_hs`/`video_vs` idle 1, pulse low 2 cycles/1 line; `video_de` timing unchanged versus the non-macro build.
